// File: rtl/sb_axi_arbiter.sv
// Two-way refill arbiter: one AXI read burst in flight at a time, round-robin between the ways.
// R beats pass straight through to the granted way; a flushed burst is drained and discarded.
module sb_axi_arbiter #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ID_BASE   = 0
) (
  input  logic        clk,
  input  logic        resetn,
  // refill requests
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_addr0,
  input  logic [31:0] req_addr1,
  output logic [1:0]  req_ready,
  input  logic        flush,
  input  logic [1:0]  hit,
  output logic        victim,
  // refill responses
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_last,
  output logic        resp_err,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        id_err
);

  localparam logic [31:0] AlignMask = ~(32'(BURST_LEN * 4) - 32'd1);
  localparam logic [3:0]  IdWay0    = 4'(ID_BASE);
  localparam logic [3:0]  IdWay1    = 4'(ID_BASE + 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q;
  logic        grant_q;
  logic        rr_q;
  logic        drop_q;
  logic        victim_q;
  logic        id_err_q;
  logic [31:0] araddr_q;
  logic [3:0]  arid_q;

  logic        grant_way;
  logic        grant_fire;
  logic        beat;
  logic        beat_ok;
  logic        fwd;
  logic [1:0]  hit_eff;

  always_comb begin
    grant_way  = (&req_valid) ? rr_q : req_valid[1];
    // resetn gates the grant so req_ready stays low while reset is held
    grant_fire = (state_q == StIdle) && (|req_valid) && resetn;
    req_ready  = 2'b00;
    if (grant_fire) begin
      req_ready = grant_way ? 2'b10 : 2'b01;
    end

    rready  = (state_q == StData);
    beat    = rready && rvalid;
    beat_ok = beat && (rid == arid_q);
    fwd     = beat_ok && !drop_q && !flush;

    resp_valid = 2'b00;
    if (fwd) begin
      resp_valid = grant_q ? 2'b10 : 2'b01;
    end
    resp_data = fwd ? rdata : 32'd0;
    resp_last = fwd && rlast;
    resp_err  = fwd && (rresp != 2'b00);

    // An explicit hit overrides the implicit hit from a grant
    hit_eff = (hit != 2'b00) ? hit : req_ready;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      drop_q   <= 1'b0;
      victim_q <= 1'b0;
      id_err_q <= 1'b0;
      araddr_q <= 32'd0;
      arid_q   <= 4'd0;
    end else begin
      if (hit_eff == 2'b01) begin
        victim_q <= 1'b1;
      end else if (hit_eff == 2'b10) begin
        victim_q <= 1'b0;
      end

      if (beat && !beat_ok) begin
        id_err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (grant_fire) begin
            grant_q  <= grant_way;
            araddr_q <= (grant_way ? req_addr1 : req_addr0) & AlignMask;
            arid_q   <= grant_way ? IdWay1 : IdWay0;
            drop_q   <= flush;
            state_q  <= StAddr;
          end
        end
        StAddr: begin
          if (flush) begin
            drop_q <= 1'b1;
          end
          if (arready) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (flush) begin
            drop_q <= 1'b1;
          end
          // Only rlast ends the burst; beats are never counted
          if (beat_ok && rlast) begin
            state_q <= StIdle;
            drop_q  <= 1'b0;
            rr_q    <= ~grant_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign arvalid = (state_q == StAddr);
  assign araddr  = araddr_q;
  assign arid    = arid_q;
  assign arlen   = 8'(BURST_LEN - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign victim  = victim_q;
  assign id_err  = id_err_q;

endmodule

// File: tb/tb_sb_axi_arbiter.sv
// Directed bench for sb_axi_arbiter: grants, AR hold, beat forwarding, flush, rid errors, LRU, reset.
module tb_sb_axi_arbiter;

  localparam int unsigned BL = 4;
  localparam logic [31:0] ALIGN = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [31:0] req_addr0, req_addr1;
  logic [1:0]  req_ready;
  logic        flush;
  logic [1:0]  hit;
  logic        victim;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic        resp_last, resp_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        id_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sb_axi_arbiter #(.BURST_LEN(BL), .ID_BASE(0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_ready  (req_ready),
    .flush      (flush),
    .hit        (hit),
    .victim     (victim),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .resp_err   (resp_err),
    .arid       (arid),
    .araddr     (araddr),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .arvalid    (arvalid),
    .arready    (arready),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready),
    .id_err     (id_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One refill burst; called and returns at posedge+1 in IDLE.
  task automatic do_burst(input string tag, input logic [1:0] rv, input logic [31:0] a0,
                          input logic [31:0] a1, input int way, input int ar_wait,
                          input int flush_at, input int bad_at, input int err_at,
                          input logic [31:0] dbase);
    logic [31:0] exp_addr;
    logic [3:0]  exp_id;
    logic [1:0]  oh;
    bit          fwd;
    exp_addr  = ((way == 1) ? a1 : a0) & ALIGN;
    exp_id    = 4'(way);
    oh        = (way == 1) ? 2'b10 : 2'b01;
    req_valid = rv;
    req_addr0 = a0;
    req_addr1 = a1;
    arready   = (ar_wait == 0);
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'(oh));
    check({tag, ".arvalid_idle"}, 32'(arvalid), 32'd0);
    tick();
    for (int c = 0; c <= ar_wait; c++) begin
      arready = (c == ar_wait);
      @(negedge clk);
      check({tag, ".arvalid"}, 32'(arvalid), 32'd1);
      check({tag, ".araddr"}, araddr, exp_addr);
      check({tag, ".arid"}, 32'(arid), 32'(exp_id));
      check({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
      if (c == 0) begin
        check({tag, ".arlen"}, 32'(arlen), 32'd3);
        check({tag, ".arsize"}, 32'(arsize), 32'd2);
        check({tag, ".arburst"}, 32'(arburst), 32'd1);
        check({tag, ".rready_addr"}, 32'(rready), 32'd0);
      end
      tick();
    end
    arready = 1'b0;
    for (int i = 0; i < int'(BL); i++) begin
      if (i == flush_at) begin
        rvalid = 1'b0;
        flush  = 1'b1;
        @(negedge clk);
        check({tag, ".flush_cycle"}, 32'(resp_valid), 32'd0);
        tick();
        flush = 1'b0;
      end
      if (i == bad_at) begin
        rvalid = 1'b1;
        rid    = 4'd7;
        rdata  = 32'hBAD0_0000;
        rlast  = 1'b0;
        rresp  = 2'b00;
        @(negedge clk);
        check({tag, ".bad_rid_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ".bad_rid_rready"}, 32'(rready), 32'd1);
        tick();
      end
      rvalid = 1'b1;
      rid    = exp_id;
      rdata  = dbase + 32'(i);
      rlast  = (i == int'(BL) - 1);
      rresp  = (i == err_at) ? 2'b10 : 2'b00;
      fwd    = !(flush_at >= 0 && i >= flush_at);
      @(negedge clk);
      check({tag, ".rready"}, 32'(rready), 32'd1);
      check({tag, ".arvalid_data"}, 32'(arvalid), 32'd0);
      check({tag, ".resp_valid"}, 32'(resp_valid), fwd ? 32'(oh) : 32'd0);
      if (fwd) begin
        check({tag, ".resp_data"}, resp_data, dbase + 32'(i));
        check({tag, ".resp_last"}, 32'(resp_last), (i == int'(BL) - 1) ? 32'd1 : 32'd0);
        check({tag, ".resp_err"}, 32'(resp_err), (i == err_at) ? 32'd1 : 32'd0);
      end
      tick();
    end
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = 2'b00;
    req_valid = 2'b00;
    @(negedge clk);
    check({tag, ".rready_done"}, 32'(rready), 32'd0);
    if (bad_at >= 0) begin
      check({tag, ".id_err"}, 32'(id_err), 32'd1);
    end
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".arvalid"}, 32'(arvalid), 32'd0);
    check({tag, ".rready"}, 32'(rready), 32'd0);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd0);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".resp_last"}, 32'(resp_last), 32'd0);
    check({tag, ".resp_err"}, 32'(resp_err), 32'd0);
    check({tag, ".id_err"}, 32'(id_err), 32'd0);
    check({tag, ".victim"}, 32'(victim), 32'd0);
    check({tag, ".araddr"}, araddr, 32'd0);
    check({tag, ".arid"}, 32'(arid), 32'd0);
    check({tag, ".resp_data"}, resp_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    req_valid = 2'b11;
    req_addr0 = 32'h0;
    req_addr1 = 32'h0;
    flush     = 1'b0;
    hit       = 2'b00;
    arready   = 1'b0;
    rid       = 4'd0;
    rdata     = 32'h0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    tick();
    @(negedge clk);
    check_reset_values("rst");
    tick();
    req_valid = 2'b00;
    resetn    = 1'b1;

    do_burst("b36", 2'b01, 32'h1FC0_0014, 32'h0, 0, 0, -1, -1, -1, 32'hA000_0000);
    @(negedge clk);
    check("b36.victim", 32'(victim), 32'd1);
    tick();

    do_burst("b38", 2'b10, 32'h0, 32'h2000_003C, 1, 5, -1, -1, -1, 32'hB000_0000);
    @(negedge clk);
    check("b38.victim", 32'(victim), 32'd0);
    tick();

    do_burst("b39", 2'b01, 32'h0000_1008, 32'h0, 0, 0, 2, -1, -1, 32'hC000_0000);
    do_burst("b39n", 2'b10, 32'h0, 32'h3000_0044, 1, 0, -1, -1, -1, 32'hC100_0000);
    do_burst("b40", 2'b01, 32'h4000_0000, 32'h0, 0, 0, -1, 1, 2, 32'hD000_0000);

    // LRU updates from hit; victim is 1 after the way-0 grant above
    hit = 2'b10; tick(); hit = 2'b00;
    @(negedge clk); check("lru.h10a", 32'(victim), 32'd0); tick();
    hit = 2'b01; tick(); hit = 2'b00;
    @(negedge clk); check("lru.h01", 32'(victim), 32'd1); tick();
    hit = 2'b11; tick(); hit = 2'b00;
    @(negedge clk); check("lru.h11", 32'(victim), 32'd1); tick();
    hit = 2'b10; tick(); hit = 2'b00;
    @(negedge clk); check("lru.h10b", 32'(victim), 32'd0);
    check("lru.id_err_sticky", 32'(id_err), 32'd1);
    tick();

    // Reset in the middle of a data phase
    req_valid = 2'b01;
    req_addr0 = 32'h5000_0000;
    arready   = 1'b1;
    tick();
    req_valid = 2'b00;
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rid     = 4'd0;
    rdata   = 32'hDEAD_BEEF;
    rlast   = 1'b0;
    @(negedge clk);
    check("mid.resp_valid", 32'(resp_valid), 32'd1);
    check("mid.victim", 32'(victim), 32'd1);
    tick();
    #1;
    resetn    = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    check_reset_values("mid_rst");
    tick();
    rvalid    = 1'b0;
    req_valid = 2'b00;
    resetn    = 1'b1;

    do_burst("b37a", 2'b11, 32'h6000_0008, 32'h7000_0018, 0, 0, -1, -1, -1, 32'hE000_0000);
    do_burst("b37b", 2'b11, 32'h6000_0008, 32'h7000_0018, 1, 0, -1, -1, -1, 32'hE100_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
